div_seq: RTL and testbench
==========================

# div_seq

Iterative sequencer for RV32M DIV/DIVU/REM/REMU that borrows the core's shared `alu` instance instead of owning a divider datapath. It runs a restoring shift-subtract algorithm: one ALU compare cycle and one ALU subtract cycle per quotient bit, plus operand-negate and result-fixup cycles. It sits beside the execute stage. The core's ALU operand/control mux selects this block's `alu_*` outputs while `busy` is high. The request and response sides each use a valid/ready handshake.

## Interface
- `WIDTH`, default 32: operand width. Iteration count equals `WIDTH`.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- `req_a` in WIDTH: dividend.
- `req_b` in WIDTH: divisor.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out WIDTH: quotient or remainder.
- `busy` out 1: high in every state except IDLE. The core routes `alu_*` from this block while high.
- `alu_in1`, `alu_in2` out WIDTH: ALU operands.
- `alu_control` out 4: ALU op, using the `alu_control.vh` encodings (`SUB`, `GTEU`, `NOP`).
- `alu_out` in WIDTH: ALU result. Combinational path from the ALU, sampled the same cycle.

## Operation
- **States:** IDLE → NEG_A → NEG_B → {CMP → SUB} ×WIDTH → FIX → DONE → IDLE.
- **IDLE, accept** (`req_valid & req_ready`), registers:
  - `a` ← `req_a`, `b` ← `req_b`, `op` ← `req_op`.
  - `sgn` = ~`req_op[0]`.
  - `a_neg` = `req_a[W-1]`, `b_neg` = `req_b[W-1]`.
  - `bz` = (`req_b` == 0).
  - `rem` ← 0, counter ← 0.
- **NEG_A:** ALU `SUB` with in1 = 0, in2 = `a`. If `sgn & a_neg`, `a` ← `alu_out`.
- **NEG_B:** same as NEG_A, applied to `b` with `b_neg`.
- **Shifted partial remainder** (combinational): `rs` = {`rem[W-2:0]`, `a[W-1]`}.
- **CMP:** ALU `GTEU` with in1 = `rs`, in2 = `b`. Register `ge` ← `alu_out[0]`.
- **SUB:** ALU `SUB` with in1 = `rs`, in2 = `b`.
  - `rem` ← `ge` ? `alu_out` : `rs`.
  - `a` ← {`a[W-2:0]`, `ge`}. `a` becomes the quotient.
  - Counter increments. After the WIDTH-th SUB, go to FIX.
- **FIX:** `res` = `op[1]` ? `rem` : `a`. Negate flag:
  - `nq` = `sgn & (a_neg ^ b_neg) & ~bz`
  - `nr` = `sgn & a_neg`
  - `n` = `op[1]` ? `nr` : `nq`.
  - ALU `SUB` with in1 = 0, in2 = `res`. `resp_data` ← `n` ? `alu_out` : `res`.
- **DONE:** `resp_valid` = 1. `resp_data` is held stable. On `resp_ready`, go to IDLE.
- **Special cases** follow from the rules above with no extra logic:
  - Divide by zero: quotient = all ones (no sign fix); remainder = dividend.
  - Signed overflow (−2^(W−1) / −1): quotient = 0x80000000, remainder = 0.
- **ALU drive outside the compute states:** in IDLE and DONE, `alu_control` = `NOP` and `alu_in1` = `alu_in2` = 0.
- **Unsigned ops** still spend the NEG_A/NEG_B cycles, with no register writes. Latency is fixed.

## Timing
- **Reset values:** state IDLE, `req_ready` 1, `resp_valid` 0, `resp_data` 0, `busy` 0, `alu_control` `NOP`, `alu_in1`/`alu_in2` 0. All internal registers clear.
- **Latency:** accept in cycle 0, so NEG_A is cycle 1 and NEG_B is cycle 2. Iterations occupy cycles 3..2W+2, FIX is cycle 2W+3, and `resp_valid` first rises in cycle 2W+4 (68 for W = 32).
- **Request side:** `req_ready` is a combinational decode of IDLE. No request is accepted in DONE. One cycle minimum between a response handshake and the next accept.
- **Response side:** `resp_valid` and `resp_data` are registered. They hold indefinitely while `resp_ready` is low. `resp_ready` outside DONE is ignored.
- **`req_*` inputs** are sampled only on the accept edge. Later changes have no effect.
- **Reset low mid-operation** (any state): next cycle is IDLE with reset values. The in-flight operation is discarded with no response.
- **ALU outputs** change only at clock edges, as registered state decodes. `alu_out` must settle within the same cycle.

## Test plan
- **DIVU 100 / 7:** `resp_data` = 14, `resp_valid` first high exactly 68 cycles after accept. Same operands as REMU → 2.
- **Signed:** DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIV 7 / −2 → 0xFFFFFFFD. REM 7 / −2 → 1.
- **Divide by zero:** DIV 5 / 0 → 0xFFFFFFFF. DIV −5 / 0 → 0xFFFFFFFF. REM −5 / 0 → 0xFFFFFFFB. DIVU 0xFFFFFFFF / 0 → 0xFFFFFFFF.
- **Overflow:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- **Backpressure:**
  - Hold `resp_ready` low for 10 cycles in DONE: `resp_valid`/`resp_data` stay stable, `req_ready` stays 0, `busy` stays 1.
  - Raise `resp_ready`: IDLE next cycle; back-to-back `req_valid` is accepted that cycle.
- **Reset mid-op:**
  - Drop `rst_n` during iteration 10: next cycle `req_ready` 1, `resp_valid` 0, `alu_control` `NOP`, no spurious response.
  - A following DIVU 0xFFFFFFFF / 3 → 0x55555555.
  - Trace check: `GTEU`/`SUB` alternate exactly 32 pairs per operation.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: iterative RV32M divide/remainder sequencer driving the core's shared ALU
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   req_valid/req_ready     request handshake; req_ready is high only in IDLE
//   req_op                  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_a, req_b            dividend and divisor, sampled on the accept edge
//   resp_valid/resp_ready   response handshake; resp_data is held while waiting
//   resp_data               quotient or remainder
//   busy                    high outside IDLE; the core muxes alu_* from here
//   alu_in1/alu_in2/alu_control  shared ALU request (decoded from registered state)
//   alu_out                 shared ALU result, used in the same cycle
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out
);
    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_GTEU = 4'b1011;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, CMP, SUB, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a, b, rem;
    logic [1:0]       op;
    logic             sgn, a_neg, b_neg, bz, ge;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rs, res;
    logic             n, iter;

    // a doubles as the dividend shift register and the quotient accumulator
    assign rs   = {rem[WIDTH-2:0], a[WIDTH-1]};
    assign res  = op[1] ? rem : a;
    // divide-by-zero quotient stays all ones; remainder follows dividend sign
    assign n    = op[1] ? (sgn & a_neg) : (sgn & (a_neg ^ b_neg) & ~bz);
    assign iter = (state == CMP) || (state == SUB);

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        alu_control = (state == IDLE || state == DONE) ? ALU_NOP :
                      (state == CMP) ? ALU_GTEU : ALU_SUB;
        alu_in1     = iter ? rs : '0;
        alu_in2     = (state == NEG_A) ? a :
                      (state == NEG_B || iter) ? b :
                      (state == FIX) ? res : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            rem        <= '0;
            op         <= '0;
            sgn        <= 1'b0;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            bz         <= 1'b0;
            ge         <= 1'b0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    a     <= req_a;
                    b     <= req_b;
                    op    <= req_op;
                    sgn   <= ~req_op[0];
                    a_neg <= req_a[WIDTH-1];
                    b_neg <= req_b[WIDTH-1];
                    bz    <= (req_b == '0);
                    rem   <= '0;
                    cnt   <= '0;
                    state <= NEG_A;
                end
                NEG_A: begin
                    if (sgn & a_neg) a <= alu_out;
                    state <= NEG_B;
                end
                NEG_B: begin
                    if (sgn & b_neg) b <= alu_out;
                    state <= CMP;
                end
                CMP: begin
                    ge    <= alu_out[0];
                    state <= SUB;
                end
                SUB: begin
                    rem   <= ge ? alu_out : rs;
                    a     <= {a[WIDTH-2:0], ge};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(WIDTH - 1)) ? FIX : CMP;
                end
                FIX: begin
                    resp_data  <= n ? alu_out : res;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq with a behavioural shared ALU
module tb_div_seq;
    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_GTEU = 4'b1011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        busy;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_control;

    int errors = 0;
    int checks = 0;
    int pairs = 0, viol = 0, ngteu = 0;
    logic prev_gteu = 1'b0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .alu_out(alu_out)
    );

    always_comb begin
        alu_out = '0;
        if (alu_control == ALU_SUB) alu_out = alu_in1 - alu_in2;
        else if (alu_control == ALU_GTEU) alu_out = {31'b0, alu_in1 >= alu_in2};
    end

    always @(negedge clk) begin
        if (prev_gteu) begin
            if (alu_control == ALU_SUB) pairs++;
            else viol++;
        end
        prev_gteu = (alu_control == ALU_GTEU);
        if (alu_control == ALU_GTEU) ngteu++;
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] d, output int lat);
        int w;
        @(negedge clk);
        req_op = o; req_a = x; req_b = y; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 200) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 2'($urandom);
        lat = 1;
        while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
        d = resp_valid ? resp_data : 'x;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (alu_control !== ALU_NOP) begin errors++; $display("FAIL reset_alu_control got %h want %h", alu_control, ALU_NOP); end
        checks++; if (alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin errors++; $display("FAIL reset_alu_in got %h/%h want 0/0", alu_in1, alu_in2); end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        logic [31:0] d;
        int lat;
        do_op(2'b01, 32'd100, 32'd7, d, lat);
        checks++; if (d !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want %h", d, 32'd14); end
        checks++; if (lat !== 68) begin errors++; $display("FAIL divu_latency got %0d want 68", lat); end
        do_op(2'b11, 32'd100, 32'd7, d, lat);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want %h", d, 32'd2); end
    endtask

    task automatic test_signed;
        logic [31:0] d;
        int lat;
        do_op(2'b00, 32'hFFFFFFF9, 32'd2, d, lat);
        checks++; if (d !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2 got %h want FFFFFFFD", d); end
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, d, lat);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_m7_2 got %h want FFFFFFFF", d); end
        do_op(2'b00, 32'd7, 32'hFFFFFFFE, d, lat);
        checks++; if (d !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7_m2 got %h want FFFFFFFD", d); end
        do_op(2'b10, 32'd7, 32'hFFFFFFFE, d, lat);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL rem_7_m2 got %h want 00000001", d); end
    endtask

    task automatic test_div_zero;
        logic [31:0] d;
        int lat;
        do_op(2'b00, 32'd5, 32'd0, d, lat);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_5_0 got %h want FFFFFFFF", d); end
        do_op(2'b00, 32'hFFFFFFFB, 32'd0, d, lat);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_m5_0 got %h want FFFFFFFF", d); end
        do_op(2'b10, 32'hFFFFFFFB, 32'd0, d, lat);
        checks++; if (d !== 32'hFFFFFFFB) begin errors++; $display("FAIL rem_m5_0 got %h want FFFFFFFB", d); end
        do_op(2'b01, 32'hFFFFFFFF, 32'd0, d, lat);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_max_0 got %h want FFFFFFFF", d); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        int lat;
        do_op(2'b00, 32'h80000000, 32'hFFFFFFFF, d, lat);
        checks++; if (d !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h want 80000000", d); end
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rem_ovf got %h want 00000000", d); end
    endtask

    task automatic test_back_to_back;
        int w;
        @(negedge clk);
        req_op = 2'b01; req_a = 32'd1000; req_b = 32'd9; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        w = 1;
        while (!resp_valid && w < 200) begin @(negedge clk); w++; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 32'd111 || req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle_%0d got v=%b d=%h rr=%b busy=%b want v=1 d=0000006f rr=0 busy=1",
                         i, resp_valid, resp_data, req_ready, busy);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        req_op = 2'b00; req_a = 32'h80000000; req_b = 32'hFFFFFFFF; req_valid = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got rr=%b v=%b want rr=1 v=0", req_ready, resp_valid); end
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got busy=%b rr=%b want busy=1 rr=0", busy, req_ready); end
        w = 1;
        while (!resp_valid && w < 200) begin @(negedge clk); w++; end
        checks++; if (w !== 68) begin errors++; $display("FAIL b2b_latency got %0d want 68", w); end
        checks++; if (resp_data !== 32'h80000000) begin errors++; $display("FAIL b2b_data got %h want 80000000", resp_data); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] d;
        int lat;
        int p0, v0, g0;
        bit seen;
        @(negedge clk);
        req_op = 2'b01; req_a = 32'h12345678; req_b = 32'd5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (22) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_resp_valid got %b want 0", resp_valid); end
        checks++; if (alu_control !== ALU_NOP) begin errors++; $display("FAIL midrst_alu_control got %h want %h", alu_control, ALU_NOP); end
        checks++; if (busy !== 1'b0 || resp_data !== 32'h0) begin errors++; $display("FAIL midrst_state got busy=%b d=%h want 0/0", busy, resp_data); end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_spurious got %b want 0", seen); end
        p0 = pairs; v0 = viol; g0 = ngteu;
        do_op(2'b01, 32'hFFFFFFFF, 32'd3, d, lat);
        checks++; if (d !== 32'h55555555) begin errors++; $display("FAIL midrst_divu got %h want 55555555", d); end
        checks++; if (pairs - p0 !== 32) begin errors++; $display("FAIL trace_pairs got %0d want 32", pairs - p0); end
        checks++; if (ngteu - g0 !== 32) begin errors++; $display("FAIL trace_gteu got %0d want 32", ngteu - g0); end
        checks++; if (viol - v0 !== 0) begin errors++; $display("FAIL trace_order got %0d want 0", viol - v0); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_overflow;
        test_back_to_back;
        test_reset_mid_op;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
